// File: rtl/hash160_pkg.sv
// Shared constants and padder state encoding for the Hash160 front end.
// The block capture logic downstream reuses the block geometry constants.
package hash160_pkg;

  localparam int unsigned BLOCK_BYTES   = 64;
  localparam logic [7:0]  PAD_MARKER    = 8'h80;
  localparam int unsigned LEN_FIELD_IDX = 56;

  typedef enum logic [1:0] {
    PadCollect = 2'd0,
    PadEmit    = 2'd1,
    PadDrain   = 2'd2
  } pad_state_e;

  // Byte idx of a single padded block holding a message of len bytes (1..55).
  function automatic logic [7:0] pad_byte(input logic [5:0] idx, input logic [5:0] len,
                                          input logic [7:0] msg);
    logic [7:0] b;
    b = 8'h00;
    if (idx < len) begin
      b = msg;
    end else if (idx == len) begin
      b = PAD_MARKER;
    end else if (idx < 6'(LEN_FIELD_IDX)) begin
      b = 8'h00;
    end else if (idx == 6'(BLOCK_BYTES - 2)) begin
      b = {7'b0, len[5]};
    end else if (idx == 6'(BLOCK_BYTES - 1)) begin
      b = {len[4:0], 3'b000};
    end
    return b;
  endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// Buffers a 1..MAX_LEN byte message and emits one padded SHA-256 block as a
// gapless 64-byte burst; overlong messages are dropped with an o_err pulse.
module sha256_msg_padder
  import hash160_pkg::*;
#(
  parameter int unsigned MAX_LEN = 55
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  input  logic       i_last,
  output logic       o_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_last,
  output logic       o_err
);

  localparam logic [5:0] MaxLenW  = 6'(MAX_LEN);
  localparam logic [5:0] LastIdxW = 6'(BLOCK_BYTES - 1);

  pad_state_e state_q;
  logic [5:0] cnt_q;
  logic [5:0] len_q;
  logic [5:0] idx_q;
  logic       o_valid_q;
  logic [7:0] o_data_q;
  logic       o_last_q;
  logic       o_err_q;
  logic [7:0] msg_buf_q [MAX_LEN];

  logic [5:0] cnt_inc;
  logic [7:0] first_byte;
  logic [7:0] buf_rd;

  assign o_ready = (state_q != PadEmit);
  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_last  = o_last_q;
  assign o_err   = o_err_q;

  assign cnt_inc = cnt_q + 6'd1;

  // Byte 0 leaves on the i_last edge; for a 1-byte message it is not yet in the buffer.
  assign first_byte = (cnt_q == 6'd0) ? i_data : msg_buf_q[0];

  always_comb begin
    buf_rd = 8'h00;
    if (idx_q < MaxLenW) begin
      buf_rd = msg_buf_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == PadCollect && i_valid && cnt_q < MaxLenW) begin
      msg_buf_q[cnt_q] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PadCollect;
      cnt_q     <= 6'd0;
      len_q     <= 6'd0;
      idx_q     <= 6'd0;
      o_valid_q <= 1'b0;
      o_data_q  <= 8'h00;
      o_last_q  <= 1'b0;
      o_err_q   <= 1'b0;
    end else begin
      o_err_q <= 1'b0;
      case (state_q)
        PadCollect: begin
          if (i_valid) begin
            if (cnt_q == MaxLenW) begin
              o_err_q <= 1'b1;
              if (i_last) begin
                cnt_q <= 6'd0;
              end else begin
                state_q <= PadDrain;
              end
            end else if (i_last) begin
              len_q     <= cnt_inc;
              idx_q     <= 6'd1;
              o_valid_q <= 1'b1;
              o_data_q  <= first_byte;
              o_last_q  <= 1'b0;
              state_q   <= PadEmit;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        PadEmit: begin
          // Byte 63 is on the port while o_last_q is high; that cycle ends the burst.
          if (o_last_q) begin
            o_valid_q <= 1'b0;
            o_data_q  <= 8'h00;
            o_last_q  <= 1'b0;
            cnt_q     <= 6'd0;
            state_q   <= PadCollect;
          end else begin
            o_data_q <= pad_byte(idx_q, len_q, buf_rd);
            o_last_q <= (idx_q == LastIdxW);
            idx_q    <= idx_q + 6'd1;
          end
        end
        PadDrain: begin
          if (i_valid && i_last) begin
            cnt_q   <= 6'd0;
            state_q <= PadCollect;
          end
        end
        default: begin
          state_q <= PadCollect;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: captures each output burst and compares
// it against hand-known bytes and a padded-block reference.
module tb_sha256_msg_padder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_last = 1'b0;
  logic       o_ready;
  logic       o_valid;
  logic [7:0] o_data;
  logic       o_last;
  logic       o_err;

  sha256_msg_padder #(.MAX_LEN(55)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_valid(i_valid),
    .i_data (i_data),
    .i_last (i_last),
    .o_ready(o_ready),
    .o_valid(o_valid),
    .o_data (o_data),
    .o_last (o_last),
    .o_err  (o_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Burst capture, sampled on the falling edge.
  logic         clr_req = 1'b0;
  logic [511:0] got_blk;
  int nbytes, first_cyc, last_cyc, last_pos, n_last, n_err, err_cyc, rdy_in_burst;

  always @(negedge clk) begin
    if (clr_req) begin
      got_blk = '0;
      nbytes = 0; first_cyc = -1; last_cyc = -1; last_pos = -1;
      n_last = 0; n_err = 0; err_cyc = -1; rdy_in_burst = 0;
    end else begin
      if (o_valid) begin
        if (nbytes == 0) first_cyc = cyc;
        if (nbytes < 64) got_blk[511-8*nbytes -: 8] = o_data;
        if (o_last) begin
          last_pos = nbytes;
          n_last++;
        end
        if (o_ready) rdy_in_burst++;
        last_cyc = cyc;
        nbytes++;
      end
      if (o_err) begin
        n_err++;
        err_cyc = cyc;
      end
    end
  end

  logic [7:0] msg [64];
  int         xcyc [64];

  task automatic check_eq(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_cap();
    clr_req = 1'b1;
    @(negedge clk);
    #1;
    clr_req = 1'b0;
  endtask

  // Send msg[0..n-1]; inputs change 1 time unit after a rising edge.
  task automatic send(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        i_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      i_valid = 1'b1;
      i_data  = msg[i];
      i_last  = (i == n - 1);
      @(posedge clk);
      #1;
      if (i < 64) xcyc[i] = cyc;
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  function automatic logic [511:0] exp_block(input int n);
    logic [511:0] b;
    logic [7:0]   v;
    logic [15:0]  bits;
    b = '0;
    bits = 16'(n * 8);
    for (int k = 0; k < 64; k++) begin
      if (k < n)       v = msg[k];
      else if (k == n) v = 8'h80;
      else if (k == 62) v = bits[15:8];
      else if (k == 63) v = bits[7:0];
      else             v = 8'h00;
      b[511-8*k -: 8] = v;
    end
    return b;
  endfunction

  function automatic logic [7:0] got_byte(input int k);
    return got_blk[511-8*k -: 8];
  endfunction

  task automatic wait_last(input string tag);
    int k = 0;
    while (n_last == 0 && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    check_eq({tag, "_done"}, 512'(n_last), 512'd1);
  endtask

  task automatic check_burst(input string tag, input int n);
    wait_last(tag);
    @(negedge clk);
    #1;
    check_eq({tag, "_rdy_back"}, 512'(o_ready), 512'd1);
    check_eq({tag, "_block"}, got_blk, exp_block(n));
    check_eq({tag, "_count"}, 512'(nbytes), 512'd64);
    check_eq({tag, "_last_pos"}, 512'(last_pos), 512'd63);
    check_eq({tag, "_gapless"}, 512'(last_cyc - first_cyc), 512'd63);
    check_eq({tag, "_no_err"}, 512'(n_err), 512'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 512'(o_ready), 512'd1);
    check_eq("rst_valid", 512'(o_valid), 512'd0);
    check_eq("rst_data", 512'(o_data), 512'd0);
    check_eq("rst_last", 512'(o_last), 512'd0);
    check_eq("rst_err", 512'(o_err), 512'd0);
    rst_n = 1'b1;
    clear_cap();
    @(posedge clk);
    #1;

    // "abc"
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send(3, 1'b0);
    check_burst("abc", 3);
    check_eq("abc_b3", 512'(got_byte(3)), 512'h80);
    check_eq("abc_b62", 512'(got_byte(62)), 512'h00);
    check_eq("abc_b63", 512'(got_byte(63)), 512'h18);

    // Single byte, first-byte latency
    clear_cap();
    msg[0] = 8'h61;
    send(1, 1'b0);
    check_burst("one", 1);
    check_eq("one_latency", 512'(first_cyc - xcyc[0]), 512'd0);
    check_eq("one_b1", 512'(got_byte(1)), 512'h80);
    check_eq("one_b63", 512'(got_byte(63)), 512'h08);

    // Maximum length with input gaps
    clear_cap();
    for (int i = 0; i < 55; i++) msg[i] = 8'(i);
    send(55, 1'b1);
    check_burst("max", 55);
    check_eq("max_b54", 512'(got_byte(54)), 512'h36);
    check_eq("max_b55", 512'(got_byte(55)), 512'h80);
    check_eq("max_b61", 512'(got_byte(61)), 512'h00);
    check_eq("max_b62", 512'(got_byte(62)), 512'h01);
    check_eq("max_b63", 512'(got_byte(63)), 512'hB8);

    // 56 bytes with last on the 56th: dropped, error pulse, stays collecting
    clear_cap();
    for (int i = 0; i < 56; i++) msg[i] = 8'(8'hA0 + i);
    send(56, 1'b0);
    repeat (80) @(negedge clk);
    #1;
    check_eq("ovf_err_cnt", 512'(n_err), 512'd1);
    check_eq("ovf_err_cyc", 512'(err_cyc - xcyc[55]), 512'd0);
    check_eq("ovf_no_burst", 512'(nbytes), 512'd0);
    clear_cap();
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send(3, 1'b0);
    check_burst("ovf_abc", 3);

    // 60 bytes: overflow at 56, rest drained
    clear_cap();
    for (int i = 0; i < 60; i++) msg[i] = 8'(8'h10 + i);
    send(60, 1'b1);
    repeat (80) @(negedge clk);
    #1;
    check_eq("drain_err_cnt", 512'(n_err), 512'd1);
    check_eq("drain_no_burst", 512'(nbytes), 512'd0);
    clear_cap();
    msg[0] = 8'h33;
    send(1, 1'b0);
    check_burst("drain_next", 1);

    // Input held valid during EMIT must be ignored
    clear_cap();
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send(3, 1'b0);
    i_valid = 1'b1;
    i_data  = 8'hEE;
    i_last  = 1'b1;
    wait_last("busy");
    i_valid = 1'b0;
    i_last  = 1'b0;
    @(negedge clk);
    #1;
    check_eq("busy_rdy_low", 512'(rdy_in_burst), 512'd0);
    check_eq("busy_block", got_blk, exp_block(3));
    clear_cap();
    msg[0] = 8'h5A;
    send(1, 1'b0);
    check_burst("busy_next", 1);
    check_eq("busy_next_b0", 512'(got_byte(0)), 512'h5A);

    // Reset in the middle of a burst
    clear_cap();
    msg[0] = 8'h77;
    send(1, 1'b0);
    begin
      int k = 0;
      while (nbytes < 21 && k < 100) begin
        @(negedge clk);
        #1;
        k++;
      end
    end
    check_eq("mid_reached", 512'(nbytes), 512'd21);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 512'(o_valid), 512'd0);
    check_eq("mid_rst_data", 512'(o_data), 512'd0);
    check_eq("mid_rst_last", 512'(o_last), 512'd0);
    check_eq("mid_rst_ready", 512'(o_ready), 512'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    clear_cap();
    @(posedge clk);
    #1;
    msg[0] = 8'h41;
    send(1, 1'b0);
    check_burst("post_rst", 1);
    check_eq("post_rst_b0", 512'(got_byte(0)), 512'h41);
    check_eq("post_rst_b63", 512'(got_byte(63)), 512'h08);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
